// File: rtl/bist_controller_if.sv
// Signal bundle between the BIST sequencer and its surroundings: run control,
// status, and the mux/response path of the 6:3 counter under test.
interface bist_controller_if;
    logic       start;
    logic [5:0] func_in;
    logic [2:0] cut_out;
    logic [5:0] cut_in;
    logic       tm;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [2:0] signature;

    modport slave (
        input  start, func_in, cut_out,
        output cut_in, tm, busy, done, pass, fail, signature
    );

    modport master (
        output start, func_in, cut_out,
        input  cut_in, tm, busy, done, pass, fail, signature
    );
endinterface

// File: rtl/bist_controller.sv
// BIST sequencer for the fast 6:3 counter: drives LFSR patterns, compresses the
// responses into a 3-bit MISR and grades the signature against a golden value.
module bist_controller #(
    parameter int         PAT_COUNT  = 7,
    parameter logic [5:0] LFSR_SEED  = 6'b000001,
    parameter logic [2:0] GOLDEN_SIG = 3'b010
) (
    input  logic             clk,
    input  logic             reset,
    bist_controller_if.slave bus
);

    if (PAT_COUNT < 1 || PAT_COUNT > 63) begin : g_bad_pat_count
        $error("bist_controller: PAT_COUNT must be in 1..63");
    end
    if (LFSR_SEED == 6'd0) begin : g_bad_seed
        $error("bist_controller: LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        APPLY,
        COMPARE,
        DONE
    } state_t;

    localparam logic [5:0] LAST_COUNT = 6'(PAT_COUNT - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] lfsr;
    logic [5:0] count;
    logic [2:0] misr;
    logic       pass_q;
    logic       fail_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pattern generator, response compactor and run counter only move in SEED/APPLY
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr  <= LFSR_SEED;
            misr  <= 3'b000;
            count <= 6'd0;
        end else begin
            case (state)
                SEED: begin
                    lfsr  <= LFSR_SEED;
                    misr  <= 3'b000;
                    count <= 6'd0;
                end
                APPLY: begin
                    misr  <= {misr[1], misr[0], misr[2] ^ misr[1]} ^ bus.cut_out;
                    lfsr  <= {lfsr[4:0], lfsr[5] ^ lfsr[0]};
                    count <= count + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Verdict is latched in COMPARE and dropped on any exit from DONE, so it is only seen in DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (state == COMPARE) begin
            pass_q <= (misr == GOLDEN_SIG);
            fail_q <= (misr != GOLDEN_SIG);
        end else if (next_state != DONE) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SEED;
            SEED:    next_state = APPLY;
            APPLY:   if (count == LAST_COUNT) next_state = COMPARE;
            COMPARE: next_state = DONE;
            DONE:    if (bus.start) next_state = SEED;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.tm        = (state == APPLY);
        bus.busy      = (state == SEED) || (state == APPLY) || (state == COMPARE);
        bus.done      = (state == DONE);
        bus.cut_in    = (state == APPLY) ? lfsr : bus.func_in;
        bus.pass      = pass_q;
        bus.fail      = fail_q;
        bus.signature = misr;
    end

endmodule
